// File: rtl/frame_pixel_streamer.sv
// Raster pixel source: reads one frame from a 1-cycle-latency RAM and streams it row-major with SOF/EOL markers.
// Optional build macro PIXEL_STREAMER_TPG_EN adds a tpg_sel input that selects a (x+y) test pattern instead of RAM data.
module frame_pixel_streamer #(
    parameter int unsigned IMG_WIDTH  = 320,
    parameter int unsigned IMG_HEIGHT = 240,
    parameter int unsigned W          = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned N         = IMG_WIDTH * IMG_HEIGHT,
    localparam int unsigned AW        = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
`ifdef PIXEL_STREAMER_TPG_EN
    input  logic          tpg_sel,
`endif
    output logic          busy,
    output logic          done,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [W-1:0]  mem_rd_data,
    output logic          y_valid,
    input  logic          y_ready,
    output logic [W-1:0]  y_data,
    output logic          y_sof,
    output logic          y_eol
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned XW = $clog2(IMG_WIDTH + 1);
    localparam int unsigned YW = $clog2(IMG_HEIGHT + 1);
    localparam int unsigned FW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = $clog2(FIFO_DEPTH + 3);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_STREAM = 2'd1, S_DONE = 2'd2} state_t;

    typedef struct packed {
        logic         sof;
        logic         eol;
        logic [W-1:0] pix;
    } entry_t;

    state_t         state_q;
    logic [CW-1:0]  rd_idx_q;
    logic [CW-1:0]  out_idx_q;
    logic [XW-1:0]  x_q;
    logic [YW-1:0]  y_q;
    logic           tpg_q;
    logic           issue_q;
    logic           inflight_q;
    entry_t         iss_ent_q;
    entry_t         fly_ent_q;
    entry_t         fifo_q [FIFO_DEPTH];
    logic [FW-1:0]  count_q;

    logic           tpg_in_c;
    logic           hs_c;
    logic           issue_c;
    logic [PW-1:0]  pending_c;
    logic [FW-1:0]  wr_idx_c;
    logic [FW-1:0]  count_n;
    entry_t         push_ent_c;
    entry_t         fifo_n [FIFO_DEPTH];

`ifdef PIXEL_STREAMER_TPG_EN
    assign tpg_in_c = tpg_sel;
`else
    assign tpg_in_c = 1'b0;
`endif

    // Issue gating counts every word not yet in the FIFO, so the FIFO can never overflow.
    always_comb begin
        hs_c       = y_valid && y_ready;
        pending_c  = PW'(count_q) + PW'(issue_q) + PW'(inflight_q);
        issue_c    = (state_q == S_STREAM) && (rd_idx_q < CW'(N)) && (pending_c < PW'(FIFO_DEPTH));
        push_ent_c = fly_ent_q;
        if (!tpg_q) begin
            push_ent_c.pix = mem_rd_data;
        end
        wr_idx_c = count_q - FW'(hs_c);
        count_n  = count_q + FW'(inflight_q) - FW'(hs_c);
        fifo_n   = fifo_q;
        if (hs_c) begin
            for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
                fifo_n[i] = fifo_q[i+1];
            end
        end
        if (inflight_q) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                if (FW'(i) == wr_idx_c) begin
                    fifo_n[i] = push_ent_c;
                end
            end
        end
    end

    // Shift FIFO keeps the head in entry 0 so the stream outputs come straight from registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rd_idx_q   <= '0;
            out_idx_q  <= '0;
            x_q        <= '0;
            y_q        <= '0;
            tpg_q      <= 1'b0;
            issue_q    <= 1'b0;
            inflight_q <= 1'b0;
            iss_ent_q  <= '0;
            fly_ent_q  <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            y_valid    <= 1'b0;
            y_data     <= '0;
            y_sof      <= 1'b0;
            y_eol      <= 1'b0;
        end else begin
            issue_q    <= issue_c;
            inflight_q <= issue_q;
            fly_ent_q  <= iss_ent_q;
            mem_rd_en  <= issue_c && !tpg_q;
            fifo_q     <= fifo_n;
            count_q    <= count_n;
            y_valid    <= (count_n != '0);
            y_data     <= (count_n != '0) ? fifo_n[0].pix : '0;
            y_sof      <= (count_n != '0) && fifo_n[0].sof;
            y_eol      <= (count_n != '0) && fifo_n[0].eol;

            if (issue_c) begin
                mem_addr      <= AW'(rd_idx_q);
                iss_ent_q.sof <= (rd_idx_q == '0);
                iss_ent_q.eol <= (x_q == XW'(IMG_WIDTH - 1));
                iss_ent_q.pix <= W'(x_q) + W'(y_q);
                rd_idx_q      <= rd_idx_q + CW'(1);
                if (x_q == XW'(IMG_WIDTH - 1)) begin
                    x_q <= '0;
                    y_q <= y_q + YW'(1);
                end else begin
                    x_q <= x_q + XW'(1);
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_STREAM;
                        busy      <= 1'b1;
                        rd_idx_q  <= '0;
                        out_idx_q <= '0;
                        x_q       <= '0;
                        y_q       <= '0;
                        tpg_q     <= tpg_in_c;
                    end
                end
                S_STREAM: begin
                    if (hs_c) begin
                        out_idx_q <= out_idx_q + CW'(1);
                        if (out_idx_q == CW'(N - 1)) begin
                            state_q <= S_DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Scoreboard bench for frame_pixel_streamer on a 4x3 frame with RAM[a] = a + 0x10.
module tb_frame_pixel_streamer;

    localparam int unsigned IW    = 4;
    localparam int unsigned IH    = 3;
    localparam int unsigned NPIX  = IW * IH;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data;
    logic          y_valid;
    logic          y_ready;
    logic [7:0]    y_data;
    logic          y_sof;
    logic          y_eol;
`ifdef PIXEL_STREAMER_TPG_EN
    logic          tpg_sel;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int hs_cnt = 0;
    int occ = 0;
    int max_occ = 0;
    int last_hs_cyc = 0;
    int ready_mode = 1;
    logic [9:0] exp_q [$];

    frame_pixel_streamer #(
        .IMG_WIDTH (IW),
        .IMG_HEIGHT(IH),
        .W         (8),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
`ifdef PIXEL_STREAMER_TPG_EN
        .tpg_sel    (tpg_sel),
`endif
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .y_valid    (y_valid),
        .y_ready    (y_ready),
        .y_data     (y_data),
        .y_sof      (y_sof),
        .y_eol      (y_eol)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame-buffer RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= 8'(mem_addr + 4'd0) + 8'h10;
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       y_ready = 1'b0;
            1:       y_ready = 1'b1;
            default: y_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and tracks words owed to the consumer.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd_en) rd_cnt++;
            occ = rd_cnt - hs_cnt;
            if (occ > max_occ) max_occ = occ;
            if (y_valid && y_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pixel: got 0x%0h expected none", {y_sof, y_eol, y_data});
                end else begin
                    check("pixel_sof_eol_data", 32'({y_sof, y_eol, y_data}), 32'(exp_q.pop_front()));
                end
                hs_cnt++;
                last_hs_cyc = cyc;
            end
        end
    end

    task automatic start_frame(input bit tpg);
        int x;
        int y;
        int pix;
        @(posedge clk);
        #1;
        rd_cnt  = 0;
        hs_cnt  = 0;
        max_occ = 0;
        start   = 1'b1;
`ifdef PIXEL_STREAMER_TPG_EN
        tpg_sel = tpg;
`endif
        for (int idx = 0; idx < int'(NPIX); idx++) begin
            x   = idx % int'(IW);
            y   = idx / int'(IW);
            pix = tpg ? (x + y) % 256 : (idx + 16) % 256;
            exp_q.push_back({(idx == 0), (x == int'(IW) - 1), 8'(pix)});
        end
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (hs_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL hs_timeout: got %0d handshakes required %0d", hs_cnt, n);
        end
    endtask

    task automatic wait_done(input bit tpg);
        bit seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done required done within 500 cycles");
            return;
        end
        check("done_after_last_hs", 32'(cyc - last_hs_cyc), 32'd1);
        check("busy_during_done", 32'(busy), 32'd1);
        check("frame_handshakes", 32'(hs_cnt), 32'(NPIX));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("reads_issued", 32'(rd_cnt), tpg ? 32'd0 : 32'(NPIX));
        check("outstanding_within_depth", 32'(max_occ <= int'(DEPTH)), 32'd1);
        @(negedge clk);
        check("done_pulse_busy_drop", 32'({done, busy}), 32'd0);
    endtask

    initial begin
        logic [10:0] held;
        int lat;
        int vcnt;
        rst_n   = 1'b0;
        start   = 1'b0;
        y_ready = 1'b0;
`ifdef PIXEL_STREAMER_TPG_EN
        tpg_sel = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({busy, done, mem_rd_en, mem_addr, y_valid, y_data, y_sof, y_eol}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-rate frame: latency, throughput and completion.
        ready_mode = 1;
        start_frame(1'b0);
        check("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) check("rd_en_one_edge_after_start", 32'(mem_rd_en), 32'd1);
            if (y_valid) break;
        end
        check("first_valid_latency", 32'(lat), 32'd3);
        vcnt = 0;
        for (int i = 0; i < int'(NPIX); i++) begin
            @(negedge clk);
            if (y_valid) vcnt++;
        end
        check("consecutive_valid_cycles", 32'(vcnt), 32'(NPIX));
        wait_done(1'b0);

        // Ten-cycle stall mid-line.
        start_frame(1'b0);
        wait_hs(5);
        ready_mode = 0;
        @(posedge clk);
        #2;
        held = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) held = {y_valid, y_sof, y_eol, y_data};
            else check("stall_outputs_hold", 32'({y_valid, y_sof, y_eol, y_data}), 32'(held));
        end
        check("stall_valid", 32'(y_valid), 32'd1);
        check("stall_rd_en_off", 32'(mem_rd_en), 32'd0);
        check("stall_outstanding_full", 32'(occ), 32'(DEPTH));
        ready_mode = 1;
        wait_done(1'b0);

        // Random backpressure.
        ready_mode = 2;
        start_frame(1'b0);
        wait_done(1'b0);
        start_frame(1'b0);
        wait_done(1'b0);

        // Start while busy is ignored; a later start replays the frame.
        ready_mode = 1;
        start_frame(1'b0);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1'b0);
        start_frame(1'b0);
        wait_done(1'b0);

        // Reset mid-frame aborts; next frame restarts at pixel 0.
        start_frame(1'b0);
        wait_hs(5);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_outputs_zero", 32'({busy, done, mem_rd_en, mem_addr, y_valid, y_data, y_sof, y_eol}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        start_frame(1'b0);
        wait_done(1'b0);

`ifdef PIXEL_STREAMER_TPG_EN
        ready_mode = 2;
        start_frame(1'b1);
        wait_done(1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish before 500000 time units");
        $fatal(1);
    end

endmodule
